friscv_dispensador_fd: RTL

// - Next-generation Frisc-V dispenser datapath/controller for N_SUCOS juice channels with one pump output each.
// - Schedules periodic distance measurements and debounces cup presence.
// - Times each dose in seconds; pauses when the cup is removed mid-pour and aborts on timeout.
// - Sits between the HC-SR04 interface (medir/medida/pronto) and the pump drivers, under the top-level UC.

---
 rtl/friscv_dispensador_fd_pkg.sv | 35 +++
 rtl/friscv_dispensador_fd_if.sv | 11 +
 rtl/friscv_dispensador_fd_filtro_copo.sv | 41 ++++
 rtl/friscv_dispensador_fd.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/friscv_dispensador_fd_pkg.sv
// Shared state codes, widths and small helpers for the Frisc-V juice dispenser controller.
package friscv_dispensador_fd_pkg;

    localparam int ESTADO_W  = 4;
    localparam int MEDIDA_W  = 12;
    localparam int SEG_W     = 8;
    localparam int MAX_SUCOS = 8;

    typedef enum logic [ESTADO_W-1:0] {
        DESLIGADO   = 4'd0,
        OCIOSO      = 4'd1,
        ESPERA_COPO = 4'd2,
        BOMBEANDO   = 4'd3,
        PAUSADO     = 4'd4,
        CONCLUIDO   = 4'd5,
        ABORTADO    = 4'd6
    } estado_t;

    function automatic logic estado_ocupado(input estado_t e);
        case (e)
            ESPERA_COPO, BOMBEANDO, PAUSADO, CONCLUIDO: estado_ocupado = 1'b1;
            default:                                    estado_ocupado = 1'b0;
        endcase
    endfunction

    // Lowest set bit wins when several buttons rise together.
    function automatic logic [2:0] menor_indice(input logic [MAX_SUCOS-1:0] v);
        menor_indice = 3'd0;
        for (int i = MAX_SUCOS - 1; i >= 0; i--) begin
            if (v[i]) menor_indice = 3'(i);
            else      menor_indice = menor_indice;
        end
    endfunction

endpackage

// File: rtl/friscv_dispensador_fd_if.sv
// Link to the HC-SR04 distance interface: measurement request out, distance and ready pulse back.
interface friscv_dispensador_fd_if;
    import friscv_dispensador_fd_pkg::*;

    logic                medir;
    logic [MEDIDA_W-1:0] medida;
    logic                medida_pronto;

    modport master (output medir, input medida, input medida_pronto);
    modport slave  (input medir, output medida, output medida_pronto);
endinterface

// File: rtl/friscv_dispensador_fd_filtro_copo.sv
// Cup-presence debounce: threshold each distance sample and flip the state only after a run of
// N_FILTRO consecutive samples that disagree with the current state.
module friscv_dispensador_fd_filtro_copo
    import friscv_dispensador_fd_pkg::*;
#(
    parameter int LIMIAR_CM = 5,
    parameter int N_FILTRO  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [MEDIDA_W-1:0] medida,
    input  logic                medida_pronto,
    output logic                copo_posicionado
);
    localparam int RUN_W = (N_FILTRO > 1) ? $clog2(N_FILTRO + 1) : 1;

    logic [RUN_W-1:0] run_r;
    logic             copo_r;
    logic             amostra_s;

    assign amostra_s        = (medida <= MEDIDA_W'(LIMIAR_CM));
    assign copo_posicionado = copo_r;

    // Count disagreeing samples; a sample matching the current state breaks the run.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_r  <= '0;
            copo_r <= 1'b0;
        end else if (medida_pronto) begin
            if (amostra_s == copo_r) begin
                run_r <= '0;
            end else if (run_r == RUN_W'(N_FILTRO - 1)) begin
                copo_r <= amostra_s;
                run_r  <= '0;
            end else begin
                run_r <= run_r + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/friscv_dispensador_fd.sv
// Frisc-V dispenser controller: measurement scheduling, button capture, dose timing with
// pause-on-cup-removal and timeout abort, one pump enable per juice channel.
module friscv_dispensador_fd
    import friscv_dispensador_fd_pkg::*;
#(
    parameter int N_SUCOS        = 2,
    parameter int CICLOS_SEG     = 50_000_000,
    parameter int PERIODO_MEDIDA = 5_000_000,
    parameter int LIMIAR_CM      = 5,
    parameter int N_FILTRO       = 3,
    parameter int DOSE_SEG       = 4,
    parameter int TIMEOUT_SEG    = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   liga,
    input  logic [N_SUCOS-1:0]     botoes,
    friscv_dispensador_fd_if.master sensor,
    output logic [N_SUCOS-1:0]     bomba,
    output logic                   copo_posicionado,
    output logic                   ocupado,
    output logic                   fim_dose,
    output logic                   erro_abort,
    output logic [ESTADO_W-1:0]    db_estado,
    output logic [SEG_W-1:0]       db_segundos
);
    localparam int TO_CICLOS = TIMEOUT_SEG * CICLOS_SEG;
    localparam int PRE_W     = (CICLOS_SEG > 1) ? $clog2(CICLOS_SEG) : 1;
    localparam int MED_W     = (PERIODO_MEDIDA > 1) ? $clog2(PERIODO_MEDIDA) : 1;
    localparam int TO_W      = (TO_CICLOS > 1) ? $clog2(TO_CICLOS) : 1;
    localparam logic [N_SUCOS-1:0] BOMBA_UM = N_SUCOS'(1);

    estado_t             state_r;
    logic [2:0]          canal_r;
    logic [PRE_W-1:0]    pre_r;
    logic [SEG_W-1:0]    seg_r;
    logic [TO_W-1:0]     to_r;
    logic [MED_W-1:0]    med_cnt_r;
    logic                medir_r;
    logic [N_SUCOS-1:0]  bomba_r;
    logic                fim_r;
    logic                erro_r;
    logic [N_SUCOS-1:0]  botoes_ant_r;
    logic [N_SUCOS-1:0]  subida_s;
    logic                copo_s;
    logic                tick_s;
    logic                to_fim_s;
    logic [SEG_W-1:0]    seg_inc_s;
    logic                dose_ok_s;

    friscv_dispensador_fd_filtro_copo #(
        .LIMIAR_CM (LIMIAR_CM),
        .N_FILTRO  (N_FILTRO)
    ) u_filtro (
        .clock            (clock),
        .reset            (reset),
        .medida           (sensor.medida),
        .medida_pronto    (sensor.medida_pronto),
        .copo_posicionado (copo_s)
    );

    assign subida_s  = botoes & ~botoes_ant_r;
    assign tick_s    = (pre_r == PRE_W'(CICLOS_SEG - 1));
    assign to_fim_s  = (to_r == TO_W'(TO_CICLOS - 1));
    assign seg_inc_s = (seg_r == 8'hFF) ? seg_r : seg_r + 8'd1;
    assign dose_ok_s = (seg_inc_s == SEG_W'(DOSE_SEG));

    // Pump enables also gate on liga so a power-off cuts them without waiting for a clock edge.
    assign bomba            = bomba_r & {N_SUCOS{liga}};
    assign copo_posicionado = copo_s;
    assign ocupado          = estado_ocupado(state_r);
    assign fim_dose         = fim_r;
    assign erro_abort       = erro_r;
    assign db_estado        = state_r;
    assign db_segundos      = seg_r;
    assign sensor.medir     = medir_r;

    // Periodic measurement request, restarting its phase whenever liga rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            med_cnt_r <= '0;
            medir_r   <= 1'b0;
        end else if (!liga) begin
            med_cnt_r <= '0;
            medir_r   <= 1'b0;
        end else if (med_cnt_r == MED_W'(PERIODO_MEDIDA - 1)) begin
            med_cnt_r <= '0;
            medir_r   <= 1'b1;
        end else begin
            med_cnt_r <= med_cnt_r + MED_W'(1);
            medir_r   <= 1'b0;
        end
    end

    // Previous button levels for rising-edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) botoes_ant_r <= '0;
        else        botoes_ant_r <= botoes;
    end

    // Dispenser FSM with dose prescaler, seconds, timeout and registered pump/pulse outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= DESLIGADO;
            canal_r <= 3'd0;
            pre_r   <= '0;
            seg_r   <= '0;
            to_r    <= '0;
            bomba_r <= '0;
            fim_r   <= 1'b0;
            erro_r  <= 1'b0;
        end else begin
            fim_r  <= 1'b0;
            erro_r <= 1'b0;
            if (!liga) begin
                state_r <= DESLIGADO;
                bomba_r <= '0;
            end else begin
                case (state_r)
                    DESLIGADO: state_r <= OCIOSO;
                    OCIOSO: begin
                        if (|subida_s) begin
                            state_r <= ESPERA_COPO;
                            canal_r <= menor_indice(MAX_SUCOS'(subida_s));
                            pre_r   <= '0;
                            seg_r   <= '0;
                            to_r    <= '0;
                        end
                    end
                    ESPERA_COPO, PAUSADO: begin
                        if (copo_s) begin
                            state_r <= BOMBEANDO;
                            bomba_r <= BOMBA_UM << canal_r;
                        end else if (to_fim_s) begin
                            state_r <= ABORTADO;
                            erro_r  <= 1'b1;
                        end else begin
                            to_r <= to_r + TO_W'(1);
                        end
                    end
                    BOMBEANDO: begin
                        // The cycle that sees the cup fall still pumped, so its tick counts.
                        if (tick_s) begin
                            pre_r <= '0;
                            seg_r <= seg_inc_s;
                        end else begin
                            pre_r <= pre_r + PRE_W'(1);
                        end
                        if (tick_s && dose_ok_s) begin
                            state_r <= CONCLUIDO;
                            bomba_r <= '0;
                            fim_r   <= 1'b1;
                        end else if (!copo_s) begin
                            state_r <= PAUSADO;
                            bomba_r <= '0;
                            to_r    <= '0;
                        end
                    end
                    CONCLUIDO: begin
                        if (!copo_s) state_r <= OCIOSO;
                    end
                    ABORTADO: state_r <= OCIOSO;
                    default: begin
                        state_r <= DESLIGADO;
                        bomba_r <= '0;
                    end
                endcase
            end
        end
    end

endmodule
